// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data port responder.
// Holds the FSM encoding, the latched request layout and the address error check.
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Misaligned or beyond the array; upper address bits are checked, never wrapped.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word array behind the responder: combinational read, single write port on posedge.
// Contents are deliberately not reset so data survives a pipeline reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];

    // Word write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: one outstanding load/store, programmable wait,
// held response with backpressure and a pipeline stall flag.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int   IDX_W    = $clog2(DEPTH);
    localparam bit   LAT_ONE  = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = LAT_ONE ? {CNT_W{1'b0}} : CNT_W'(LATENCY - 2);

    dmem_state_t      state_r;
    dmem_state_t      state_next_s;
    logic [CNT_W-1:0] cnt_r;
    dmem_req_t        req_r;
    dmem_req_t        cur_req_s;
    logic             accept_s;
    logic             enter_resp_s;
    logic             err_s;
    logic             arr_we_s;
    logic [31:0]      arr_rdata_s;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;
    logic             req_ready_s;
    logic             rsp_valid_s;
    logic             stall_s;

    assign accept_s = (state_r == IDLE) && bus.req_valid;

    // With LATENCY==1 the access happens on the accept edge, so it must see the live request.
    always_comb begin
        cur_req_s = req_r;
        if (state_r == IDLE) begin
            cur_req_s = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        end else begin
            cur_req_s = req_r;
        end
    end

    assign enter_resp_s = (accept_s && LAT_ONE) ||
                          ((state_r == WAIT) && (cnt_r == {CNT_W{1'b0}}));
    assign err_s        = addr_err(cur_req_s.addr, 32'(DEPTH));
    assign arr_we_s     = enter_resp_s && cur_req_s.we && !err_s;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .idx   (cur_req_s.addr[IDX_W+1:2]),
        .wdata (cur_req_s.wdata),
        .rdata (arr_rdata_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = LAT_ONE ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake and stall outputs decoded from the state flop.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                stall_s     = bus.req_valid;
            end
            WAIT: begin
                stall_s = 1'b1;
            end
            RESP: begin
                rsp_valid_s = 1'b1;
                stall_s     = !bus.rsp_ready;
            end
            default: begin
                req_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
                stall_s     = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_r       <= '0;
            cnt_r       <= {CNT_W{1'b0}};
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                req_r <= cur_req_s;
                cnt_r <= CNT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (enter_resp_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (!err_s && !cur_req_s.we) ? arr_rdata_s : 32'h0000_0000;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.stall     = stall_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Lockstep bench: a LATENCY=2 and a LATENCY=1 responder see identical stimulus and are
// checked every cycle against a transaction-level countdown model with its own word array.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_we, d_rready;
    logic [31:0] d_addr, d_wdata;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_valid = d_valid;  assign bus1.req_valid = d_valid;
    assign bus0.req_we    = d_we;     assign bus1.req_we    = d_we;
    assign bus0.req_addr  = d_addr;   assign bus1.req_addr  = d_addr;
    assign bus0.req_wdata = d_wdata;  assign bus1.req_wdata = d_wdata;
    assign bus0.rsp_ready = d_rready; assign bus1.rsp_ready = d_rready;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    logic        o_rr [2];
    logic        o_rv [2];
    logic        o_st [2];
    logic        o_er [2];
    logic [31:0] o_rd [2];
    assign o_rr[0] = bus0.req_ready; assign o_rr[1] = bus1.req_ready;
    assign o_rv[0] = bus0.rsp_valid; assign o_rv[1] = bus1.rsp_valid;
    assign o_st[0] = bus0.stall;     assign o_st[1] = bus1.stall;
    assign o_er[0] = bus0.rsp_err;   assign o_er[1] = bus1.rsp_err;
    assign o_rd[0] = bus0.rsp_rdata; assign o_rd[1] = bus1.rsp_rdata;

    // Reference model: per responder, idle/responding flags plus cycles left before the response.
    int          lat [2] = '{2, 1};
    bit          m_idle [2];
    bit          m_resp [2];
    int          m_left [2];
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    bit          m_err [2];
    bit          m_rk [2];
    logic [31:0] mem_m [2][DEPTH];
    bit          known [2][DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idle[d] = 1'b1; m_resp[d] = 1'b0; m_left[d] = 0;
            m_rdata[d] = 32'h0; m_err[d] = 1'b0; m_rk[d] = 1'b1;
        end
    endtask

    task automatic model_access(input int d);
        logic [31:0] w;
        bit          e;
        w = m_addr[d] >> 2;
        e = (m_addr[d] % 4 != 0) || (w >= DEPTH);
        m_err[d]   = e;
        m_rdata[d] = 32'h0;
        m_rk[d]    = 1'b1;
        if (!e && m_we[d]) begin
            mem_m[d][w] = m_wdata[d];
            known[d][w] = 1'b1;
        end else if (!e) begin
            m_rdata[d] = mem_m[d][w];
            m_rk[d]    = known[d][w];
        end
        m_resp[d] = 1'b1;
    endtask

    // One clock cycle: drive after negedge, check, advance the model at posedge.
    task automatic step(input bit v, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit rr);
        d_valid = v; d_we = we; d_addr = a; d_wdata = wd; d_rready = rr;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_req_ready", d), 32'(o_rr[d]), 32'(m_idle[d]));
            check_eq($sformatf("d%0d_rsp_valid", d), 32'(o_rv[d]), 32'(m_resp[d]));
            check_eq($sformatf("d%0d_stall", d), 32'(o_st[d]),
                     32'((m_idle[d] && v) || (!m_idle[d] && !m_resp[d]) || (m_resp[d] && !rr)));
            if (m_resp[d]) begin
                check_eq($sformatf("d%0d_rsp_err", d), 32'(o_er[d]), 32'(m_err[d]));
                if (m_rk[d]) check_eq($sformatf("d%0d_rsp_rdata", d), o_rd[d], m_rdata[d]);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (m_resp[d]) begin
                if (rr) begin m_resp[d] = 1'b0; m_idle[d] = 1'b1; end
            end else if (m_idle[d]) begin
                if (v) begin
                    m_we[d] = we; m_addr[d] = a; m_wdata[d] = wd;
                    m_idle[d] = 1'b0; m_left[d] = lat[d] - 1;
                    if (m_left[d] == 0) model_access(d);
                end
            end else begin
                m_left[d]--;
                if (m_left[d] == 0) model_access(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !(m_idle[0] && m_idle[1]); i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        if (!(m_idle[0] && m_idle[1])) check_eq("drain_timeout", 32'h0, 32'h1);
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input int hold);
        drain();
        step(1'b1, we, a, wd, 1'b1);
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic check_in_reset();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_rsp_valid", d), 32'(o_rv[d]), 32'h0);
            check_eq($sformatf("d%0d_rst_rdata", d), o_rd[d], 32'h0);
            check_eq($sformatf("d%0d_rst_err", d), 32'(o_er[d]), 32'h0);
            check_eq($sformatf("d%0d_rst_req_ready", d), 32'(o_rr[d]), 32'h1);
        end
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_rready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_in_reset();
        @(negedge clk);
        reset = 1'b1;

        // Store/load round trip and a word to protect across reset.
        txn(1'b1, 32'h08, 32'h1234_5678, 0);
        txn(1'b0, 32'h08, 32'h0, 0);
        txn(1'b1, 32'h10, 32'h1111_0000, 0);
        txn(1'b1, 32'h00, 32'hA5A5_0001, 0);

        // Reset while the LATENCY=2 store sits in WAIT.
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
        #2 reset = 1'b0;
        model_reset();
        #1 check_in_reset();
        @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 32'h10, 32'h0, 0);

        // Backpressure, errors and back-to-back loads.
        txn(1'b0, 32'h08, 32'h0, 5);
        txn(1'b0, 32'h06, 32'h0, 0);
        txn(1'b1, 32'h100, 32'hFFFF_FFFF, 0);
        txn(1'b0, 32'h00, 32'h0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, (i % 2 == 0) ? 32'h00 : 32'h04, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h08, 32'h0, (i == 3));
        drain();

        // Random traffic including busy-time input changes.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
                1:       a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
                default: a = $urandom_range(0, 15) << 2;
            endcase
            step(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, a, $urandom,
                 ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
